// File: rtl/wb_result_queue.sv
// Writeback result queue: merges X/Y/M completions into one age-ordered FIFO
// and retires one register-file write per cycle, with issue backpressure.
module wb_result_queue #(
    parameter int DEPTH    = 8,
    parameter int HEADROOM = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   x_wb_writereg,
    input  logic [4:0]             x_wb_regdest,
    input  logic [31:0]            x_wb_wbvalue,
    input  logic                   y_wb_writereg,
    input  logic [4:0]             y_wb_regdest,
    input  logic [31:0]            y_wb_wbvalue,
    input  logic                   m_wb_writereg,
    input  logic [4:0]             m_wb_regdest,
    input  logic [31:0]            m_wb_wbvalue,
    output logic                   wb_reg_en,
    output logic [4:0]             wb_reg_addr,
    output logic [31:0]            wb_reg_data,
    output logic                   wbq_stall,
    output logic [$clog2(DEPTH):0] wbq_count,
    output logic                   wbq_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - HEADROOM);

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] slot_y;
    logic [AW-1:0] slot_m;
    logic [CW-1:0] count;
    logic [CW-1:0] space;
    logic [CW-1:0] used;
    logic [CW-1:0] count_next;
    logic          cand_x, cand_y, cand_m;
    logic          acc_x, acc_y, acc_m;
    logic          pop;
    logic          drop;

    // Space counts the slot freed by this cycle's pop; candidates are granted
    // in fixed X, Y, M priority so same-cycle results keep a stable order.
    always_comb begin
        cand_x = x_wb_writereg && (x_wb_regdest != 5'd0);
        cand_y = y_wb_writereg && (y_wb_regdest != 5'd0);
        cand_m = m_wb_writereg && (m_wb_regdest != 5'd0);
        pop    = (count != '0);
        space  = DEPTH_C - count + CW'(pop);
        used   = '0;
        acc_x  = cand_x && (used < space);
        used   = used + CW'(acc_x);
        acc_y  = cand_y && (used < space);
        used   = used + CW'(acc_y);
        acc_m  = cand_m && (used < space);
        used   = used + CW'(acc_m);
        slot_y = tail + AW'(acc_x);
        slot_m = tail + AW'(acc_x) + AW'(acc_y);
        drop   = (cand_x && !acc_x) || (cand_y && !acc_y) || (cand_m && !acc_m);
        count_next = count + used - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (acc_x) mem[tail]   <= {x_wb_regdest, x_wb_wbvalue};
        if (acc_y) mem[slot_y] <= {y_wb_regdest, y_wb_wbvalue};
        if (acc_m) mem[slot_m] <= {m_wb_regdest, m_wb_wbvalue};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            wb_reg_en    <= 1'b0;
            wb_reg_addr  <= '0;
            wb_reg_data  <= '0;
            wbq_overflow <= 1'b0;
        end else begin
            head         <= head + AW'(pop);
            tail         <= tail + AW'(used);
            count        <= count_next;
            wb_reg_en    <= pop;
            wbq_overflow <= wbq_overflow || drop;
            if (pop) begin
                wb_reg_addr <= mem[head][36:32];
                wb_reg_data <= mem[head][31:0];
            end
        end
    end

    assign wbq_count = count;
    assign wbq_stall = (count > STALL_TH);
endmodule

// File: tb/tb_wb_result_queue.sv
// Self-checking bench for wb_result_queue: scoreboard of expected register
// writes plus cycle-exact checks of latency, occupancy, stall and overflow.
module tb_wb_result_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        x_wb_writereg, y_wb_writereg, m_wb_writereg;
    logic [4:0]  x_wb_regdest, y_wb_regdest, m_wb_regdest;
    logic [31:0] x_wb_wbvalue, y_wb_wbvalue, m_wb_wbvalue;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic        wbq_stall;
    logic [3:0]  wbq_count;
    logic        wbq_overflow;

    logic [36:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    wb_result_queue #(.DEPTH(8), .HEADROOM(3)) dut (
        .clock(clock), .reset(reset),
        .x_wb_writereg(x_wb_writereg), .x_wb_regdest(x_wb_regdest), .x_wb_wbvalue(x_wb_wbvalue),
        .y_wb_writereg(y_wb_writereg), .y_wb_regdest(y_wb_regdest), .y_wb_wbvalue(y_wb_wbvalue),
        .m_wb_writereg(m_wb_writereg), .m_wb_regdest(m_wb_regdest), .m_wb_wbvalue(m_wb_wbvalue),
        .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
        .wbq_stall(wbq_stall), .wbq_count(wbq_count), .wbq_overflow(wbq_overflow)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic xv, input logic [4:0] xr, input logic [31:0] xd,
                         input logic yv, input logic [4:0] yr, input logic [31:0] yd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        x_wb_writereg = xv; x_wb_regdest = xr; x_wb_wbvalue = xd;
        y_wb_writereg = yv; y_wb_regdest = yr; y_wb_wbvalue = yd;
        m_wb_writereg = mv; m_wb_regdest = mr; m_wb_wbvalue = md;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        logic [36:0] got, want;
        drive(1, 5'd5, 32'h0000_00AA, 0, 0, 0, 0, 0, 0);
        exp_q.push_back({5'd5, 32'h0000_00AA});
        step(); idle();
        checks++;
        if (wb_reg_en !== 1'b0 || wbq_count !== 4'd1) begin
            failures++;
            $display("FAIL single_cyc1 en=%b count=%0d want en=0 count=1", wb_reg_en, wbq_count);
        end
        step();
        checks++;
        if (wb_reg_en !== 1'b1) begin
            failures++;
            $display("FAIL single_cyc2_en en=%b want 1", wb_reg_en);
        end else begin
            checks++;
            got = {wb_reg_addr, wb_reg_data}; want = exp_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL single_data got=%h want=%h", got, want);
            end
        end
        step();
        checks++;
        if (wb_reg_en !== 1'b0 || wbq_count !== 4'd0) begin
            failures++;
            $display("FAIL single_cyc3 en=%b count=%0d want en=0 count=0", wb_reg_en, wbq_count);
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        logic [36:0] got, want;
        drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 5'd3, 32'h33);
        exp_q.push_back({5'd1, 32'h11});
        exp_q.push_back({5'd2, 32'h22});
        exp_q.push_back({5'd3, 32'h33});
        step(); idle();
        checks++;
        if (wbq_count !== 4'd3 || wb_reg_en !== 1'b0) begin
            failures++;
            $display("FAIL simul_peak count=%0d en=%b want count=3 en=0", wbq_count, wb_reg_en);
        end
        for (int c = 2; c <= 4; c++) begin
            step();
            checks++;
            if (wb_reg_en !== 1'b1 || exp_q.size() == 0) begin
                failures++;
                $display("FAIL simul_en cyc=%0d en=%b want 1", c, wb_reg_en);
            end else begin
                got = {wb_reg_addr, wb_reg_data}; want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL simul_order cyc=%0d got=%h want=%h", c, got, want);
                end
            end
        end
        step();
        checks++;
        if (wb_reg_en !== 1'b0) begin
            failures++;
            $display("FAIL simul_cyc5 en=%b want 0", wb_reg_en);
        end
        exp_q.delete();
    endtask

    task automatic test_same_reg();
        logic [36:0] got, want;
        drive(0, 0, 0, 1, 5'd7, 32'hA, 0, 0, 0);
        exp_q.push_back({5'd7, 32'hA});
        step();
        drive(1, 5'd7, 32'hB, 0, 0, 0, 0, 0, 0);
        exp_q.push_back({5'd7, 32'hB});
        step(); idle();
        for (int c = 2; c <= 3; c++) begin
            checks++;
            if (wb_reg_en !== 1'b1 || exp_q.size() == 0) begin
                failures++;
                $display("FAIL samereg_en cyc=%0d en=%b want 1", c, wb_reg_en);
            end else begin
                got = {wb_reg_addr, wb_reg_data}; want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL samereg_order cyc=%0d got=%h want=%h", c, got, want);
                end
            end
            step();
        end
        checks++;
        if (wb_reg_en !== 1'b0) begin
            failures++;
            $display("FAIL samereg_cyc4 en=%b want 0", wb_reg_en);
        end
        exp_q.delete();
    endtask

    task automatic test_r0_invalid();
        logic [36:0] got, want;
        drive(0, 5'd6, 32'h66, 0, 5'd9, 32'h99, 1, 5'd0, 32'hFFFF_FFFF);
        step(); idle();
        checks++;
        if (wbq_count !== 4'd0 || wbq_overflow !== 1'b0) begin
            failures++;
            $display("FAIL r0_count count=%0d ovf=%b want count=0 ovf=0", wbq_count, wbq_overflow);
        end
        step();
        checks++;
        if (wb_reg_en !== 1'b0) begin
            failures++;
            $display("FAIL r0_en en=%b want 0", wb_reg_en);
        end
        // valid X alongside an r0 write and an idle Y: only X may land
        drive(1, 5'd4, 32'h44, 0, 5'd8, 32'h88, 1, 5'd0, 32'h1234);
        exp_q.push_back({5'd4, 32'h44});
        step(); idle();
        checks++;
        if (wbq_count !== 4'd1) begin
            failures++;
            $display("FAIL r0_mixed_count count=%0d want 1", wbq_count);
        end
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
            step();
            if (wb_reg_en === 1'b1) begin
                checks++;
                got = {wb_reg_addr, wb_reg_data}; want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL r0_mixed_data got=%h want=%h", got, want);
                end
            end
        end
        step();
        checks++;
        if (exp_q.size() != 0 || wb_reg_en !== 1'b0) begin
            failures++;
            $display("FAIL r0_drain left=%0d en=%b want left=0 en=0", exp_q.size(), wb_reg_en);
        end
        exp_q.delete();
    endtask

    task automatic test_stall_overflow();
        logic [36:0] got, want;
        int exp_cnt[5] = '{3, 5, 7, 8, 8};
        logic exp_stall[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_ovf[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                drive(1, 5'(1 + 3 * k), 32'hC000_0000 | 32'(k << 4),
                      1, 5'(2 + 3 * k), 32'hC000_0001 | 32'(k << 4),
                      1, 5'(3 + 3 * k), 32'hC000_0002 | 32'(k << 4));
                for (int u = 0; u < 3; u++)
                    exp_q.push_back({5'(1 + 3 * k + u), 32'hC000_0000 | 32'(k << 4) | 32'(u)});
            end else if (k == 3) begin
                drive(1, 5'd10, 32'hD10, 1, 5'd11, 32'hD11, 0, 0, 0);
                exp_q.push_back({5'd10, 32'hD10});
                exp_q.push_back({5'd11, 32'hD11});
            end else begin
                drive(1, 5'd12, 32'hD12, 1, 5'd13, 32'hD13, 1, 5'd14, 32'hD14);
                exp_q.push_back({5'd12, 32'hD12});
            end
            step();
            checks++;
            if (wbq_count !== 4'(exp_cnt[k]) || wbq_stall !== exp_stall[k] ||
                wbq_overflow !== exp_ovf[k]) begin
                failures++;
                $display("FAIL fill_state k=%0d count=%0d stall=%b ovf=%b want %0d %b %b",
                         k, wbq_count, wbq_stall, wbq_overflow, exp_cnt[k], exp_stall[k], exp_ovf[k]);
            end
            if (wb_reg_en === 1'b1) begin
                checks++;
                got = {wb_reg_addr, wb_reg_data}; want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL fill_order k=%0d got=%h want=%h", k, got, want);
                end
            end
        end
        idle();
        for (int c = 0; c < 32 && exp_q.size() > 0; c++) begin
            step();
            if (wb_reg_en === 1'b1) begin
                checks++;
                got = {wb_reg_addr, wb_reg_data}; want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL drain_order got=%h want=%h", got, want);
                end
            end
        end
        step();
        checks++;
        if (exp_q.size() != 0 || wbq_count !== 4'd0 || wb_reg_en !== 1'b0) begin
            failures++;
            $display("FAIL drain_end left=%0d count=%0d en=%b want 0 0 0",
                     exp_q.size(), wbq_count, wb_reg_en);
        end
        checks++;
        if (wbq_overflow !== 1'b1 || wbq_stall !== 1'b0) begin
            failures++;
            $display("FAIL ovf_held ovf=%b stall=%b want ovf=1 stall=0", wbq_overflow, wbq_stall);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd20, 32'hDEAD_0000 | 32'(k), 1, 5'd21, 32'hBEEF_0000, 1, 5'd22, 32'hCAFE_0000);
            step();
        end
        idle();
        checks++;
        if (wbq_stall !== 1'b1 || wb_reg_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre stall=%b en=%b want 1 1", wbq_stall, wb_reg_en);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (wb_reg_en !== 1'b0 || wb_reg_addr !== 5'd0 || wb_reg_data !== 32'd0) begin
            failures++;
            $display("FAIL rst_async_out en=%b addr=%0d data=%h want 0 0 0",
                     wb_reg_en, wb_reg_addr, wb_reg_data);
        end
        checks++;
        if (wbq_count !== 4'd0 || wbq_stall !== 1'b0 || wbq_overflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_state count=%0d stall=%b ovf=%b want 0 0 0",
                     wbq_count, wbq_stall, wbq_overflow);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (wb_reg_en !== 1'b0 || wbq_count !== 4'd0) begin
            failures++;
            $display("FAIL rst_after en=%b count=%0d want 0 0", wb_reg_en, wbq_count);
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (wb_reg_en !== 1'b0 || wb_reg_addr !== 5'd0 || wb_reg_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_out en=%b addr=%0d data=%h want 0 0 0",
                     wb_reg_en, wb_reg_addr, wb_reg_data);
        end
        checks++;
        if (wbq_count !== 4'd0 || wbq_stall !== 1'b0 || wbq_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state count=%0d stall=%b ovf=%b want 0 0 0",
                     wbq_count, wbq_stall, wbq_overflow);
        end
        reset = 1'b0;
        step();
        test_single();
        test_simultaneous();
        test_same_reg();
        test_r0_invalid();
        test_stall_overflow();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
